// File: rtl/sdram_pattern_tester_if.sv
// Request/response bus between the pattern tester (master) and the SDRAM controller (slave).
interface sdram_pattern_tester_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_enable;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_enable;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              busy;

  modport master (
    output wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    input  rd_data, rd_ready, busy
  );

  modport slave (
    input  wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    output rd_data, rd_ready, busy
  );
endinterface

// File: rtl/sdram_pattern_tester.sv
// Writes an address-keyed pattern through the SDRAM controller, reads it back and
// reports pass/fail, error count and the first failing address/data.
module sdram_pattern_tester #(
  parameter int                ADDR_W    = 25,
  parameter int                DATA_W    = 16,
  parameter int                NUM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] SEED      = 16'h3D1A,
  parameter int                TIMEOUT   = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [15:0]           err_count_o,
  output logic [ADDR_W-1:0]     first_err_addr_o,
  output logic [DATA_W-1:0]     first_err_data_o,
  sdram_pattern_tester_if.master bus
);

  localparam int                TW        = $clog2(TIMEOUT + 1) + 1;
  localparam logic [TW-1:0]     TMO_MAX   = TW'(TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_ACK, S_WR_DONE, S_RD_REQ, S_RD_ACK, S_RD_DATA, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              got_q, got_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       err_q, err_d;
  logic              ferr_seen_q, ferr_seen_d;
  logic [ADDR_W-1:0] ferr_addr_q, ferr_addr_d;
  logic [DATA_W-1:0] ferr_data_q, ferr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              err_inc;
  logic              tmo_hit;
  logic              data_ok;

  function automatic logic [DATA_W-1:0] expected(input logic [ADDR_W-1:0] a);
    return a[DATA_W-1:0] ^ SEED;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE_ADDR;
      tmo_q       <= '0;
      got_q       <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
      ferr_seen_q <= 1'b0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tmo_q       <= tmo_d;
      got_q       <= got_d;
      running_q   <= running_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      ferr_seen_q <= ferr_seen_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tmo_d       = tmo_q;
    got_d       = got_q;
    running_d   = running_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    ferr_seen_d = ferr_seen_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = wr_en_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = rd_en_q;
    err_inc     = 1'b0;
    data_ok     = got_q;
    tmo_hit     = (tmo_q == TMO_MAX);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i && !running_q) begin
          running_d   = 1'b1;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
          err_d       = '0;
          ferr_seen_d = 1'b0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          addr_d      = BASE_ADDR;
          state_d     = bus.busy ? S_IDLE : S_WR_REQ;
        end else if (running_q && !bus.busy) begin
          // Controller finished initialising after start was accepted.
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = expected(addr_q);
        state_d   = S_WR_ACK;
      end
      S_WR_ACK: begin
        if (bus.busy || tmo_hit) begin
          timeout_d = timeout_q | ~bus.busy;
          wr_en_d   = 1'b0;
          wr_addr_d = '0;
          wr_data_d = '0;
          state_d   = S_WR_DONE;
        end
      end
      S_WR_DONE: begin
        if (!bus.busy) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = BASE_ADDR;
            state_d = S_RD_REQ;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        rd_en_d   = 1'b1;
        rd_addr_d = addr_q;
        got_d     = 1'b0;
        state_d   = S_RD_ACK;
      end
      S_RD_ACK: begin
        if (bus.busy || tmo_hit) begin
          timeout_d = timeout_q | ~bus.busy;
          rd_en_d   = 1'b0;
          rd_addr_d = '0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.rd_ready && !got_q) begin
          got_d   = 1'b1;
          data_ok = 1'b1;
          if (bus.rd_data != expected(addr_q)) begin
            err_inc = 1'b1;
            if (!ferr_seen_q) begin
              ferr_seen_d = 1'b1;
              ferr_addr_d = addr_q;
              ferr_data_d = bus.rd_data;
            end
          end
        end
        if ((data_ok && !bus.busy) || tmo_hit) begin
          // A read that never returned data counts as one error.
          if (!(data_ok && !bus.busy)) begin
            timeout_d = 1'b1;
            err_inc   = ~data_ok;
          end
          if (addr_q == LAST_ADDR) begin
            running_d = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_RD_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_inc && err_q != 16'hFFFF) err_d = err_q + 16'd1;

    if (state_d != state_q)
      tmo_d = '0;
    else if (state_q inside {S_WR_ACK, S_RD_ACK, S_RD_DATA})
      tmo_d = tmo_q + 1'b1;
  end

  assign running_o        = running_q;
  assign done_o           = done_q;
  assign pass_o           = done_q && (err_q == 16'd0) && !timeout_q;
  assign timeout_o        = timeout_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = ferr_addr_q;
  assign first_err_data_o = ferr_data_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.wr_enable    = wr_en_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.rd_enable    = rd_en_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench: behavioural SDRAM controller model plus a scoreboard of the
// write/read sequence and error status the tester must produce.
module tb_sdram_pattern_tester;

  localparam int          ADDR_W = 25;
  localparam int          DATA_W = 16;
  localparam int          NW     = 4;
  localparam logic [15:0] SEED   = 16'h3D1A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic running, done, pass, timeout;
  logic [15:0] err_count;
  logic [ADDR_W-1:0] ferr_addr;
  logic [DATA_W-1:0] ferr_data;

  sdram_pattern_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_pattern_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NW),
    .BASE_ADDR('0), .SEED(SEED), .TIMEOUT(1023)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .running_o(running), .done_o(done), .pass_o(pass), .timeout_o(timeout),
    .err_count_o(err_count), .first_err_addr_o(ferr_addr), .first_err_data_o(ferr_data),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Controller model state
  int          busy_cnt = 0;
  int          init_cnt = 0;
  int          corrupt_addr = -1;
  int          drop_addr = -1;
  logic        cur_is_rd = 1'b0;
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [15:0] mem [0:15];

  // Scoreboard state
  int          wr_idx, rd_idx, ready_cnt, mism;
  bit          m_first_seen, en_during_init;
  logic [ADDR_W-1:0] m_first_addr, rd_cur;
  logic [15:0] m_first_data;
  logic [15:0] wr_log [0:7];

  function automatic logic [15:0] model_exp(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ SEED;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_clear();
    wr_idx = 0; rd_idx = 0; ready_cnt = 0; mism = 0;
    m_first_seen = 0; m_first_addr = '0; m_first_data = '0; en_during_init = 0;
  endtask

  // SDRAM controller model: accept, busy for 3 cycles, rd_ready 2 cycles after accept.
  initial begin
    bus.busy = 1'b0; bus.rd_ready = 1'b0; bus.rd_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.rd_ready = 1'b0;
      if (init_cnt > 0) begin
        init_cnt--;
        bus.busy = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (cur_is_rd && busy_cnt == 1 && int'(cur_addr) != drop_addr) begin
          bus.rd_ready = 1'b1;
          bus.rd_data  = (int'(cur_addr) == corrupt_addr) ? 16'h0000 : mem[cur_addr[3:0]];
        end
        bus.busy = (busy_cnt != 0);
      end else if (bus.wr_enable) begin
        cur_is_rd = 1'b0; cur_addr = bus.wr_addr;
        mem[bus.wr_addr[3:0]] = bus.wr_data;
        busy_cnt = 3; bus.busy = 1'b1;
      end else if (bus.rd_enable) begin
        cur_is_rd = 1'b1; cur_addr = bus.rd_addr;
        busy_cnt = 3; bus.busy = 1'b1;
      end else begin
        bus.busy = 1'b0;
      end
    end
  end

  // Compare process: every accepted request is checked against the expected sequence.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wr_enable || bus.rd_enable)
          check("enable exclusive", 32'(bus.wr_enable & bus.rd_enable), 32'd0);
        if (init_cnt > 0 && (bus.wr_enable || bus.rd_enable)) en_during_init = 1;
        if (bus.wr_enable && bus.busy) begin
          check("write count bound", 32'(wr_idx < NW), 32'd1);
          check("write addr", 32'(bus.wr_addr), 32'(wr_idx));
          check("write data", 32'(bus.wr_data), 32'(model_exp(ADDR_W'(wr_idx))));
          wr_log[wr_idx % 8] = bus.wr_data;
          wr_idx++;
        end
        if (bus.rd_enable && bus.busy) begin
          check("reads after all writes", 32'(wr_idx), 32'(NW));
          check("read addr", 32'(bus.rd_addr), 32'(rd_idx));
          rd_cur = bus.rd_addr;
          rd_idx++;
        end
        if (bus.rd_ready) begin
          ready_cnt++;
          if (bus.rd_data !== model_exp(rd_cur)) begin
            mism++;
            if (!m_first_seen) begin
              m_first_seen = 1; m_first_addr = rd_cur; m_first_data = bus.rd_data;
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset running", 32'(running), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset pass", 32'(pass), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    check("reset enables", 32'({bus.wr_enable, bus.rd_enable}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string t);
    int n = 0;
    while (!done && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("%s done within budget", t), 32'(done), 32'd1);
  endtask

  task automatic end_checks(input string t, input int e_err, input bit e_to, input bit e_pass);
    check($sformatf("%s running", t), 32'(running), 32'd0);
    check($sformatf("%s err_count", t), 32'(err_count), 32'(e_err));
    check($sformatf("%s timeout", t), 32'(timeout), 32'(e_to));
    check($sformatf("%s pass", t), 32'(pass), 32'(e_pass));
    check($sformatf("%s writes seen", t), 32'(wr_idx), 32'(NW));
    check($sformatf("%s reads seen", t), 32'(rd_idx), 32'(NW));
    check($sformatf("%s model err", t), 32'(err_count), 32'(mism + rd_idx - ready_cnt));
    check($sformatf("%s first_err_addr", t), 32'(ferr_addr), 32'(m_first_addr));
    check($sformatf("%s first_err_data", t), 32'(ferr_data), 32'(m_first_data));
  endtask

  initial begin
    int n;
    bit found;
    sb_clear();
    do_reset();

    // T1: clean pass
    pulse_start();
    check("T1 running after start", 32'(running), 32'd1);
    check("T1 done cleared", 32'(done), 32'd0);
    wait_done("T1");
    end_checks("T1", 0, 1'b0, 1'b1);
    check("T1 data word0", 32'(wr_log[0]), 32'h3D1A);
    check("T1 data word1", 32'(wr_log[1]), 32'h3D1B);
    check("T1 data word2", 32'(wr_log[2]), 32'h3D18);
    check("T1 data word3", 32'(wr_log[3]), 32'h3D19);

    // T2: corrupted read of address 2, started from DONE
    sb_clear(); corrupt_addr = 2;
    pulse_start();
    wait_done("T2");
    end_checks("T2", 1, 1'b0, 1'b0);
    check("T2 first_err_addr literal", 32'(ferr_addr), 32'd2);
    check("T2 first_err_data literal", 32'(ferr_data), 32'h0000);
    corrupt_addr = -1;

    // T4: no rd_ready for address 1
    sb_clear(); drop_addr = 1;
    pulse_start();
    check("T4 status cleared on start", 32'(err_count), 32'd0);
    wait_done("T4");
    end_checks("T4", 1, 1'b1, 1'b0);
    drop_addr = -1;

    // T6: start while running is ignored
    sb_clear();
    pulse_start();
    n = 0;
    while (wr_idx < 2 && n < 200) begin @(posedge clk); n++; end
    pulse_start();
    check("T6 still running", 32'(running), 32'd1);
    wait_done("T6");
    end_checks("T6", 0, 1'b0, 1'b1);

    // T3: controller busy for 500 cycles after reset
    sb_clear(); init_cnt = 500;
    do_reset();
    repeat (10) @(posedge clk);
    pulse_start();
    check("T3 running while init busy", 32'(running), 32'd1);
    check("T3 no write while init busy", 32'(bus.wr_enable), 32'd0);
    n = 0;
    while (init_cnt > 0 && n < 700) begin @(posedge clk); n++; end
    check("T3 no enable during init", 32'(en_during_init), 32'd0);
    wait_done("T3");
    end_checks("T3", 0, 1'b0, 1'b1);

    // T5: reset during the write of word 2, then a clean rerun
    sb_clear();
    pulse_start();
    n = 0; found = 0;
    while (!found && n < 200) begin
      @(negedge clk); n++;
      found = bus.wr_enable && (bus.wr_addr == 25'd2);
    end
    check("T5 reached word 2", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("T5 wr_enable drops in reset", 32'(bus.wr_enable), 32'd0);
    check("T5 running cleared", 32'(running), 32'd0);
    check("T5 done cleared", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    sb_clear();
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    wait_done("T5");
    end_checks("T5", 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
